// File: rtl/fasm_pkg.sv
// rtl/fasm_pkg.sv - shared constants for the two-port byte-lane SRAM
package fasm_pkg;

    localparam int LANE_W   = 8;
    localparam int RLAT_MIN = 1;
    localparam int RLAT_MAX = 2;

endpackage

// File: rtl/fasm_tpsram_core.sv
// rtl/fasm_tpsram_core.sv - unreset storage array: byte-lane write port, asynchronous read port
module fasm_tpsram_core
    import fasm_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_adr,
    input  logic [DW-1:0]        wr_dat,
    input  logic [DW/LANE_W-1:0] wr_sel,
    input  logic [AW-1:0]        rd_adr,
    output logic [DW-1:0]        rd_dat
);

    localparam int LANES = DW / LANE_W;

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int n = 0; n < LANES; n++) begin
                if (wr_sel[n]) begin
                    mem[wr_adr][n*LANE_W +: LANE_W] <= wr_dat[n*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign rd_dat = mem[rd_adr];

endmodule

// File: rtl/fasm_tpsram.sv
// rtl/fasm_tpsram.sv - two-port SRAM wrapper: read pipeline, write ack, optional FASM_TPSRAM_BYPASS_EN forwarding
module fasm_tpsram
    import fasm_pkg::*;
#(
    parameter int AW   = 4,
    parameter int DW   = 32,
    parameter int RLAT = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AW-1:0]        adr_i,
    input  logic                 stb_i,
    output logic [DW-1:0]        dat_o,
    output logic                 ack_o,
    input  logic [AW-1:0]        xadr_i,
    input  logic [DW-1:0]        xdat_i,
    input  logic [DW/LANE_W-1:0] xsel_i,
    input  logic                 xwre_i,
    input  logic                 xstb_i,
    output logic                 xack_o
);

    localparam int LANES = DW / LANE_W;

    logic          wr_en;
    logic [DW-1:0] mem_dat;
    logic [DW-1:0] rd_dat;
    logic          s1_vld;
    logic [DW-1:0] s1_dat;

    // Writes are blocked while reset is held since the array itself is never reset.
    assign wr_en = xstb_i & xwre_i & ~rst_i;

    fasm_tpsram_core #(
        .AW(AW),
        .DW(DW)
    ) u_core (
        .clk    (clk_i),
        .wr_en  (wr_en),
        .wr_adr (xadr_i),
        .wr_dat (xdat_i),
        .wr_sel (xsel_i),
        .rd_adr (adr_i),
        .rd_dat (mem_dat)
    );

`ifdef FASM_TPSRAM_BYPASS_EN
    always_comb begin
        rd_dat = mem_dat;
        if (wr_en && (xadr_i == adr_i)) begin
            for (int n = 0; n < LANES; n++) begin
                if (xsel_i[n]) begin
                    rd_dat[n*LANE_W +: LANE_W] = xdat_i[n*LANE_W +: LANE_W];
                end
            end
        end
    end
`else
    assign rd_dat = mem_dat;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            xack_o <= 1'b0;
        end else begin
            s1_vld <= stb_i;
            if (stb_i) begin
                s1_dat <= rd_dat;
            end
            xack_o <= wr_en;
        end
    end

    // Data registers only load on a valid beat so dat_o holds the last acknowledged word.
    generate
        if (RLAT == RLAT_MAX) begin : g_rlat2
            logic          s2_vld;
            logic [DW-1:0] s2_dat;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    s2_vld <= 1'b0;
                    s2_dat <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_dat <= s1_dat;
                    end
                end
            end

            assign ack_o = s2_vld;
            assign dat_o = s2_dat;
        end else begin : g_rlat1
            assign ack_o = s1_vld;
            assign dat_o = s1_dat;
        end
    endgenerate

endmodule

// File: tb/tb_fasm_tpsram.sv
// tb/tb_fasm_tpsram.sv - random and directed checks of fasm_tpsram at RLAT 1 and 2 against a cycle-scheduled model
module tb_fasm_tpsram;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int NCYC  = 2048;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] adr = '0;
    logic          stb = 1'b0;
    logic [AW-1:0] xadr = '0;
    logic [DW-1:0] xdat = '0;
    logic [3:0]    xsel = '0;
    logic          xwre = 1'b0;
    logic          xstb = 1'b0;

    logic [DW-1:0] dat1, dat2;
    logic          ack1, ack2, xack1, xack2;

    always #5 clk = ~clk;

    fasm_tpsram #(.AW(AW), .DW(DW), .RLAT(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .stb_i(stb), .dat_o(dat1), .ack_o(ack1),
        .xadr_i(xadr), .xdat_i(xdat), .xsel_i(xsel), .xwre_i(xwre), .xstb_i(xstb), .xack_o(xack1)
    );

    fasm_tpsram #(.AW(AW), .DW(DW), .RLAT(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .stb_i(stb), .dat_o(dat2), .ack_o(ack2),
        .xadr_i(xadr), .xdat_i(xdat), .xsel_i(xsel), .xwre_i(xwre), .xstb_i(xstb), .xack_o(xack2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DW-1:0] mem_m [DEPTH];
    bit            exp_v1 [NCYC];
    bit            exp_v2 [NCYC];
    bit            exp_x  [NCYC];
    logic [DW-1:0] exp_d1 [NCYC];
    logic [DW-1:0] exp_d2 [NCYC];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last2 = '0;
    logic [DW-1:0] lit;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input bit wr,
                                                 input logic [AW-1:0] xa, input logic [DW-1:0] xd,
                                                 input logic [3:0] xl);
        logic [DW-1:0] v;
        v = mem_m[a];
`ifdef FASM_TPSRAM_BYPASS_EN
        if (wr && xa == a) begin
            for (int n = 0; n < DW/8; n++) begin
                if (xl[n]) v[8*n +: 8] = xd[8*n +: 8];
            end
        end
`endif
        return v;
    endfunction

    task automatic step(input bit r, input bit s, input logic [AW-1:0] a, input bit xs, input bit xw,
                        input logic [3:0] xl, input logic [AW-1:0] xa, input logic [DW-1:0] xd);
        logic [DW-1:0] rv;
        @(negedge clk);
        rst = r; stb = s; adr = a; xstb = xs; xwre = xw; xsel = xl; xadr = xa; xdat = xd;
        if (r) begin
            for (int i = cyc + 1; i < NCYC; i++) begin
                exp_v1[i] = 1'b0;
                exp_v2[i] = 1'b0;
                exp_x[i]  = 1'b0;
            end
            last1 = '0;
            last2 = '0;
        end
        @(posedge clk);
        cyc++;
        if (!r) begin
            if (s) begin
                rv = model_read(a, xs && xw, xa, xd, xl);
                exp_v1[cyc]   = 1'b1;
                exp_d1[cyc]   = rv;
                exp_v2[cyc+1] = 1'b1;
                exp_d2[cyc+1] = rv;
            end
            if (xs && xw) begin
                for (int n = 0; n < DW/8; n++) begin
                    if (xl[n]) mem_m[xa][8*n +: 8] = xd[8*n +: 8];
                end
                exp_x[cyc] = 1'b1;
            end
        end
        #1;
        if (exp_v1[cyc]) last1 = exp_d1[cyc];
        if (exp_v2[cyc]) last2 = exp_d2[cyc];
        check("ack1",  32'(ack1),  32'(exp_v1[cyc]));
        check("ack2",  32'(ack2),  32'(exp_v2[cyc]));
        check("dat1",  dat1, last1);
        check("dat2",  dat2, last2);
        check("xack1", 32'(xack1), 32'(exp_x[cyc]));
        check("xack2", 32'(xack2), 32'(exp_x[cyc]));
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, '0, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] l);
        step(0, 0, '0, 1, 1, l, a, d);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(0, 1, a, 0, 0, '0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            exp_v1[i] = 1'b0; exp_v2[i] = 1'b0; exp_x[i] = 1'b0;
            exp_d1[i] = '0;   exp_d2[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

        #2 rst = 1'b1;
        #1;
        check("rst_ack1",  32'(ack1),  32'd0);
        check("rst_ack2",  32'(ack2),  32'd0);
        check("rst_dat1",  dat1, 32'd0);
        check("rst_dat2",  dat2, 32'd0);
        check("rst_xack1", 32'(xack1), 32'd0);
        step(1, 1, 4'h1, 1, 1, 4'hF, 4'h1, 32'h5555_5555);
        step(1, 0, '0, 0, 0, '0, '0, '0);
        idle();

        for (int a = 0; a < DEPTH; a++) wr(AW'(a), 32'h0, 4'hF);
        idle();

        wr(4'h3, 32'hA5A5_A5A5, 4'hF);
        check("x_ack_after_write", 32'(xack1), 32'd1);
        rd(4'h3);
        idle();
        check("full_write_dat1", dat1, 32'hA5A5_A5A5);
        check("full_write_dat2", dat2, 32'hA5A5_A5A5);

        wr(4'h3, 32'h1122_3344, 4'b0101);
        rd(4'h3);
        idle();
        check("lane_write_dat1", dat1, 32'hA522_A544);
        check("lane_write_dat2", dat2, 32'hA522_A544);

        step(0, 1, 4'h7, 1, 1, 4'hF, 4'h7, 32'hDEAD_BEEF);
        idle();
`ifdef FASM_TPSRAM_BYPASS_EN
        lit = 32'hDEAD_BEEF;
`else
        lit = 32'h0;
`endif
        check("same_edge_dat1", dat1, lit);
        check("same_edge_dat2", dat2, lit);
        rd(4'h7);
        idle();
        check("same_edge_after", dat1, 32'hDEAD_BEEF);

        for (int a = 0; a < 4; a++) wr(AW'(a), 32'h10 + DW'(a), 4'hF);
        for (int a = 0; a < 4; a++) rd(AW'(a));
        idle(); idle(); idle();
        check("b2b_last_dat2", dat2, 32'h13);

        step(0, 0, '0, 1, 0, 4'hF, 4'hF, 32'hFFFF_FFFF);
        check("no_wre_xack", 32'(xack1), 32'd0);
        rd(4'hF);
        idle();
        check("no_wre_contents", dat1, 32'h0);
        wr(4'hF, 32'hCAFE_F00D, 4'hF);
        wr(4'h0, 32'h1234_5678, 4'hF);
        rd(4'hF);
        rd(4'h0);
        idle();
        check("addr_0_distinct", dat1, 32'h1234_5678);
        idle();

        step(0, 1, 4'h2, 1, 1, 4'hF, 4'h9, 32'h9999_0909);
        step(1, 0, '0, 0, 0, '0, '0, '0);
        step(1, 0, '0, 0, 0, '0, '0, '0);
        idle(); idle(); idle();
        rd(4'h9);
        idle();
        check("write_kept_over_rst", dat1, 32'h9999_0909);

        repeat (400) begin
            step($urandom_range(0, 63) == 0, 1'($urandom), AW'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom), AW'($urandom), $urandom);
        end
        idle(); idle(); idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
